// File: rtl/pcpu_fetch_pkg.sv
// Fetch stage shared types.
// State encoding, default widths and queue entry layout.
package pcpu_fetch_pkg;

  localparam int FETCH_AW = 7;
  localparam int FETCH_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries.
// Registered storage, head read straight from the array, no bypass.
module fetch_fifo
  import pcpu_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  // storage, pointers and occupancy; flush drops everything at once
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, single-outstanding memory request, prefetch queue.
// Redirects flush the queue and mark any in-flight response as stale.
module instruction_fetch_unit
  import pcpu_fetch_pkg::*;
#(
  parameter int            DEPTH    = 4,
  parameter int            AW       = FETCH_AW,
  parameter int            DW       = FETCH_DW,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          SysCLK,
  input  logic          SysRST,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [AW-1:0] if_pc,
  output logic [DW-1:0] if_instr
);

  localparam int            CW  = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   LIM = (CW + 1)'(DEPTH);

  fetch_state_e  state;
  logic [AW-1:0] pc;
  logic [AW-1:0] req_pc;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          busy;
  logic          issue;
  logic          push;
  logic          pop;
  fetch_entry_t  wdata;
  fetch_entry_t  head;

  assign busy  = (state != IDLE);
  assign occ   = {1'b0, count} + {{CW{1'b0}}, busy};
  assign issue = ~SysRST & ~redirect & (occ < LIM)
               & (~busy | mem_rvalid);
  assign push  = (state == WAIT) & mem_rvalid & ~redirect;
  assign pop   = if_valid & if_ready & ~redirect;

  assign mem_req  = issue;
  assign mem_addr = pc;

  assign wdata.pc    = req_pc;
  assign wdata.instr = mem_rdata;

  // PC, request address tracking and the in-flight state machine
  always_ff @(posedge SysCLK) begin
    if (SysRST) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      if (redirect)   pc <= redirect_pc;
      else if (issue) pc <= pc + 1'b1;
      if (issue) req_pc <= pc;
      if (redirect) begin
        state <= (mem_rvalid | ~busy) ? IDLE : DROP;
      end else begin
        unique case (state)
          IDLE:       if (issue) state <= WAIT;
          WAIT, DROP: if (mem_rvalid) state <= issue ? WAIT : IDLE;
          default:    state <= IDLE;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (SysCLK),
    .rst   (SysRST),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .din   (wdata),
    .head  (head),
    .valid (if_valid),
    .count (count)
  );

  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order memory model with
// programmable latency, scoreboard queues for requests and fetched pairs.
module tb_instruction_fetch_unit;
  import pcpu_fetch_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          if_valid;
  logic          if_ready = 1'b0;
  logic [AW-1:0] if_pc;
  logic [DW-1:0] if_instr;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .DEPTH    (4),
    .AW       (AW),
    .DW       (DW),
    .RESET_PC (7'd0)
  ) dut (
    .SysCLK      (clk),
    .SysRST      (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  pend_t         pend[$];
  logic [AW-1:0] exp_addr[$];
  logic [AW-1:0] exp_pc[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            lat = 1;
  bit            addr_strict = 1'b0;
  bit            ok;

  function automatic logic [DW-1:0] img(input logic [AW-1:0] a);
    return {8'hA5, 1'b0, a, 9'h000, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_mem_req"},  32'(mem_req),  32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_if_pc"},    32'(if_pc),    32'd0);
    chk({tag, "_if_instr"}, if_instr,      32'd0);
  endtask

  task automatic do_reset(input int l, input string tag);
    tick();
    rst = 1'b1;
    redirect = 1'b0;
    @(negedge clk);
    pend.delete();
    exp_addr.delete();
    exp_pc.delete();
    addr_strict = 1'b0;
    lat = l;
    tick();
    @(negedge clk);
    reset_checks(tag);
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input logic [AW-1:0] a, output bit found);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == a) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_req: no request for %h", a);
    end
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while ((exp_addr.size() != 0 || exp_pc.size() != 0) && i < 300) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (exp_addr.size() != 0 || exp_pc.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d addr and %0d pc expectations left",
               tag, exp_addr.size(), exp_pc.size());
    end
  endtask

  // memory: in-order responses, lat cycles after each request
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = img(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  // request capture and scoreboard monitor
  always @(negedge clk) begin : mon
    logic [AW-1:0] e;
    if (mem_req) begin
      pend.push_back('{addr: mem_addr, due: cyc + lat});
      if (exp_addr.size() != 0) begin
        e = exp_addr.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(e));
      end else if (addr_strict) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_req: got addr %h expected no request", mem_addr);
      end
    end
    if (if_valid && if_ready && !redirect && exp_pc.size() != 0) begin
      e = exp_pc.pop_front();
      chk("if_pc",    32'(if_pc), 32'(e));
      chk("if_instr", if_instr,   img(e));
    end
    if (dut.push) chk("push_not_full", 32'(dut.count == 3'd4), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: latency 1, always ready, one instruction per cycle
    if_ready = 1'b1;
    do_reset(1, "t1_rst");
    for (int i = 0; i < 10; i++) begin
      exp_addr.push_back(AW'(i));
      exp_pc.push_back(AW'(i));
    end
    @(negedge clk);
    chk("t1_c1_req",   32'(mem_req),  32'd1);
    chk("t1_c1_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    chk("t1_c2_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_stream_valid", 32'(if_valid), 32'd1);
    end
    drain("t1");

    // T2: downstream stalled, exactly DEPTH requests, then resume
    if_ready = 1'b0;
    do_reset(1, "t2_rst");
    addr_strict = 1'b1;
    for (int i = 0; i < 4; i++) exp_addr.push_back(AW'(i));
    repeat (12) @(negedge clk);
    chk("t2_req_left", 32'(exp_addr.size()), 32'd0);
    chk("t2_hold_valid", 32'(if_valid), 32'd1);
    chk("t2_hold_pc",    32'(if_pc),    32'd0);
    repeat (3) @(negedge clk);
    chk("t2_hold_pc2",    32'(if_pc), 32'd0);
    chk("t2_hold_instr2", if_instr,   img(7'd0));
    tick();
    addr_strict = 1'b0;
    for (int i = 4; i < 12; i++) exp_addr.push_back(AW'(i));
    for (int i = 0; i < 12; i++) exp_pc.push_back(AW'(i));
    if_ready = 1'b1;
    drain("t2");

    // T3: latency 3, redirect to 0x40 while request 5 is in flight
    if_ready = 1'b1;
    do_reset(3, "t3_rst");
    for (int i = 0; i < 6; i++) exp_addr.push_back(AW'(i));
    exp_addr.push_back(7'h40);
    exp_addr.push_back(7'h41);
    for (int i = 0; i < 4; i++) exp_pc.push_back(AW'(i));
    exp_pc.push_back(7'h40);
    exp_pc.push_back(7'h41);
    wait_req(7'd5, ok);
    tick();
    redirect    = 1'b1;
    redirect_pc = 7'h40;
    @(negedge clk);
    chk("t3_redir_noreq", 32'(mem_req), 32'd0);
    tick();
    redirect = 1'b0;
    drain("t3");

    // T4: redirect coincides with a response and a pop
    if_ready = 1'b1;
    do_reset(1, "t4_rst");
    for (int i = 0; i < 4; i++) exp_addr.push_back(AW'(i));
    exp_addr.push_back(7'h20);
    exp_addr.push_back(7'h21);
    exp_pc.push_back(7'd0);
    exp_pc.push_back(7'd1);
    exp_pc.push_back(7'h20);
    exp_pc.push_back(7'h21);
    wait_req(7'd3, ok);
    tick();
    redirect    = 1'b1;
    redirect_pc = 7'h20;
    @(negedge clk);
    chk("t4_redir_head_valid", 32'(if_valid), 32'd1);
    chk("t4_redir_head_pc",    32'(if_pc),    32'd2);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_after_empty", 32'(if_valid), 32'd0);
    chk("t4_after_idle",  32'(dut.state == IDLE), 32'd1);
    chk("t4_after_req",   32'(mem_req), 32'd1);
    drain("t4");

    // T5: PC wraps from 0x7F to 0x00
    if_ready = 1'b1;
    do_reset(1, "t5_rst");
    redirect    = 1'b1;
    redirect_pc = 7'h7F;
    exp_addr.push_back(7'h7F);
    exp_addr.push_back(7'h00);
    exp_addr.push_back(7'h01);
    exp_pc.push_back(7'h7F);
    exp_pc.push_back(7'h00);
    exp_pc.push_back(7'h01);
    @(negedge clk);
    chk("t5_redir_noreq", 32'(mem_req), 32'd0);
    tick();
    redirect = 1'b0;
    drain("t5");

    // T6: reset mid-stream with entries queued and a request in flight
    if_ready = 1'b0;
    do_reset(3, "t6_rst");
    for (int i = 0; i < 4; i++) exp_addr.push_back(AW'(i));
    wait_req(7'd3, ok);
    chk("t6_pre_valid", 32'(if_valid), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    reset_checks("t6_mid");
    exp_addr.delete();
    exp_pc.delete();
    for (int i = 0; i < 3; i++) begin
      exp_addr.push_back(AW'(i));
      exp_pc.push_back(AW'(i));
    end
    tick();
    rst = 1'b0;
    if_ready = 1'b1;
    @(negedge clk);
    chk("t6_restart_req", 32'(mem_req), 32'd1);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
